// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 32-bit RISC CPU control path:
//   - IR field bit positions (opcode, Ra, Rb, Rc)
//   - 5-bit opcode encodings
//   - control_sequencer step encoding (T0..T7, HALT)
//   - opcode classification used to select the execute sequence
// -----------------------------------------------------------------------------
package cpu_pkg;

   // IR field positions
   localparam int OP_MSB = 31;
   localparam int OP_LSB = 27;
   localparam int RA_MSB = 26;
   localparam int RA_LSB = 23;
   localparam int RB_MSB = 22;
   localparam int RB_LSB = 19;
   localparam int RC_MSB = 18;
   localparam int RC_LSB = 15;

   // Opcodes
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ST   = 5'b00001;
   localparam logic [4:0] OP_ADD  = 5'b00010;
   localparam logic [4:0] OP_SUB  = 5'b00011;
   localparam logic [4:0] OP_AND  = 5'b00100;
   localparam logic [4:0] OP_OR   = 5'b00101;
   localparam logic [4:0] OP_SHR  = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_ADDI = 5'b01010;
   localparam logic [4:0] OP_ANDI = 5'b01011;
   localparam logic [4:0] OP_ORI  = 5'b01100;
   localparam logic [4:0] OP_MUL  = 5'b01101;
   localparam logic [4:0] OP_DIV  = 5'b01110;
   localparam logic [4:0] OP_NEG  = 5'b01111;
   localparam logic [4:0] OP_NOT  = 5'b10000;
   localparam logic [4:0] OP_JR   = 5'b10001;
   localparam logic [4:0] OP_IN   = 5'b10010;
   localparam logic [4:0] OP_MFHI = 5'b10011;
   localparam logic [4:0] OP_MFLO = 5'b10100;
   localparam logic [4:0] OP_NOP  = 5'b10101;
   localparam logic [4:0] OP_HALT = 5'b10110;

   // Sequencer steps
   localparam logic [3:0] ST_T0   = 4'd0;
   localparam logic [3:0] ST_T1   = 4'd1;
   localparam logic [3:0] ST_T2   = 4'd2;
   localparam logic [3:0] ST_T3   = 4'd3;
   localparam logic [3:0] ST_T4   = 4'd4;
   localparam logic [3:0] ST_T5   = 4'd5;
   localparam logic [3:0] ST_T6   = 4'd6;
   localparam logic [3:0] ST_T7   = 4'd7;
   localparam logic [3:0] ST_HALT = 4'd8;

   // Execute-sequence families
   typedef enum logic [2:0] {
      CLS_ALU3,
      CLS_IMM,
      CLS_UNARY,
      CLS_MULDIV,
      CLS_LOAD,
      CLS_STORE,
      CLS_SINGLE,
      CLS_UNDEF
   } op_class_t;

   function automatic op_class_t classify(input logic [4:0] op);
      op_class_t c;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL:    c = CLS_ALU3;
         OP_ADDI, OP_ANDI, OP_ORI:          c = CLS_IMM;
         OP_NEG, OP_NOT:                    c = CLS_UNARY;
         OP_MUL, OP_DIV:                    c = CLS_MULDIV;
         OP_LD:                             c = CLS_LOAD;
         OP_ST:                             c = CLS_STORE;
         OP_JR, OP_IN, OP_MFHI, OP_MFLO,
         OP_NOP, OP_HALT:                   c = CLS_SINGLE;
         default:                           c = CLS_UNDEF;
      endcase
      return c;
   endfunction

   // Immediate forms reuse the ALU code of their register-register sibling
   function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
      logic [4:0] a;
      case (op)
         OP_ANDI: a = OP_AND;
         OP_ORI:  a = OP_OR;
         default: a = OP_ADD;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// -----------------------------------------------------------------------------
// reg_select_decoder
// Turns a 4-bit register number into a 16-bit one-hot select.
//   field   in  4   register number
//   en      in  1   when low the output is all zeros
//   onehot  out 16  bit n high when en=1 and field=n
// -----------------------------------------------------------------------------
module reg_select_decoder (
   input  logic [3:0]  field,
   input  logic        en,
   output logic [15:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[field] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit for the 32-bit RISC CPU. Steps the fetch (T0-T2) and
// execute (T3-T7) sequences decoded from the IR and drives every datapath
// strobe as a combinational function of the step register and ir.
//
// Ports
//   clock, clear            rising-edge clock, synchronous active-high reset
//   ir[31:0]                IR contents (opcode, Ra, Rb, Rc)
//   mem_ready               memory finished the current Read/Write
//   stop                    halt request, taken at an instruction boundary
//   *out, CSignOut          bus source selects (at most one high)
//   Rout[15:0], Rin[15:0]   one-hot register bus select / load enable
//   MARin..Write            datapath enables and memory strobes
//   alu_op[4:0]             ALU opcode
//   run                     low only in HALT
//   instr_done              one-cycle pulse on the last step of an instruction
//   illegal                 sticky undefined-opcode flag
//
// Build option: define ILLEGAL_TRAP_EN to trap undefined opcodes (10111-11111)
// into HALT with illegal=1; otherwise they execute as nop and illegal is 0.
// -----------------------------------------------------------------------------
module control_sequencer
   import cpu_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   input  logic        stop,
   output logic        PCout,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        HIout,
   output logic        LOout,
   output logic        Yout,
   output logic        InPortout,
   output logic        CSignOut,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        MARin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        HIin,
   output logic        LOin,
   output logic        ZHighIn,
   output logic        ZLowIn,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic [4:0]  alu_op,
   output logic        run,
   output logic        instr_done,
   output logic        illegal
);

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   op_class_t  cls;
   logic       rout_en;
   logic [3:0] rout_field;
   logic       rin_en;
   logic       done;
   logic       halt_req;
   logic       ir_unused;

   assign opcode    = ir[OP_MSB:OP_LSB];
   assign ra        = ir[RA_MSB:RA_LSB];
   assign rb        = ir[RB_MSB:RB_LSB];
   assign rc        = ir[RC_MSB:RC_LSB];
   assign cls       = classify(opcode);
   assign ir_unused = ^ir[RC_LSB-1:0];

`ifdef ILLEGAL_TRAP_EN
   logic illegal_set;
   logic illegal_q;
`endif

   // Step decode: everything stays 0 while clear is high so an abort never
   // leaves a partial strobe on the datapath.
   always_comb begin
      PCout      = 1'b0;
      Zhighout   = 1'b0;
      Zlowout    = 1'b0;
      MDRout     = 1'b0;
      HIout      = 1'b0;
      LOout      = 1'b0;
      Yout       = 1'b0;
      InPortout  = 1'b0;
      CSignOut   = 1'b0;
      MARin      = 1'b0;
      PCin       = 1'b0;
      MDRin      = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      HIin       = 1'b0;
      LOin       = 1'b0;
      ZHighIn    = 1'b0;
      ZLowIn     = 1'b0;
      IncPC      = 1'b0;
      Read       = 1'b0;
      Write      = 1'b0;
      alu_op     = 5'd0;
      rout_en    = 1'b0;
      rout_field = ra;
      rin_en     = 1'b0;
      done       = 1'b0;
      halt_req   = 1'b0;
      state_nxt  = state;
`ifdef ILLEGAL_TRAP_EN
      illegal_set = 1'b0;
`endif
      if (!clear) begin
         case (state)
            ST_T0: begin
               PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
               state_nxt = ST_T1;
            end
            ST_T1: begin
               Read = 1'b1; MDRin = 1'b1;
               if (mem_ready) state_nxt = ST_T2;
            end
            ST_T2: begin
               MDRout = 1'b1; IRin = 1'b1;
               state_nxt = ST_T3;
            end
            ST_T3: begin
               case (cls)
                  CLS_ALU3, CLS_IMM, CLS_LOAD, CLS_STORE: begin
                     rout_en = 1'b1; rout_field = rb; Yin = 1'b1;
                     state_nxt = ST_T4;
                  end
                  CLS_UNARY: begin
                     rout_en = 1'b1; rout_field = rb;
                     alu_op = opcode; ZLowIn = 1'b1;
                     state_nxt = ST_T4;
                  end
                  CLS_MULDIV: begin
                     rout_en = 1'b1; rout_field = ra; Yin = 1'b1;
                     state_nxt = ST_T4;
                  end
                  CLS_SINGLE: begin
                     done = 1'b1;
                     case (opcode)
                        OP_JR:   begin rout_en = 1'b1; PCin = 1'b1; end
                        OP_IN:   begin InPortout = 1'b1; rin_en = 1'b1; end
                        OP_MFHI: begin HIout = 1'b1; rin_en = 1'b1; end
                        OP_MFLO: begin LOout = 1'b1; rin_en = 1'b1; end
                        OP_HALT: halt_req = 1'b1;
                        default: ;
                     endcase
                  end
                  default: begin
`ifdef ILLEGAL_TRAP_EN
                     illegal_set = 1'b1;
                     state_nxt   = ST_HALT;
`else
                     done = 1'b1;
`endif
                  end
               endcase
            end
            ST_T4: begin
               state_nxt = ST_T5;
               case (cls)
                  CLS_ALU3: begin
                     rout_en = 1'b1; rout_field = rc;
                     alu_op = opcode; ZLowIn = 1'b1;
                  end
                  CLS_IMM: begin
                     CSignOut = 1'b1; alu_op = imm_alu_op(opcode); ZLowIn = 1'b1;
                  end
                  CLS_UNARY: begin
                     Zlowout = 1'b1; rin_en = 1'b1; done = 1'b1;
                  end
                  CLS_MULDIV: begin
                     rout_en = 1'b1; rout_field = rb; alu_op = opcode;
                     ZHighIn = 1'b1; ZLowIn = 1'b1;
                  end
                  CLS_LOAD, CLS_STORE: begin
                     CSignOut = 1'b1; alu_op = OP_ADD; ZLowIn = 1'b1;
                  end
                  default: state_nxt = ST_T0;
               endcase
            end
            ST_T5: begin
               state_nxt = ST_T6;
               case (cls)
                  CLS_ALU3, CLS_IMM: begin
                     Zlowout = 1'b1; rin_en = 1'b1; done = 1'b1;
                  end
                  CLS_MULDIV:          begin Zlowout = 1'b1; LOin = 1'b1; end
                  CLS_LOAD, CLS_STORE: begin Zlowout = 1'b1; MARin = 1'b1; end
                  default:             state_nxt = ST_T0;
               endcase
            end
            ST_T6: begin
               state_nxt = ST_T7;
               case (cls)
                  CLS_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
                  CLS_LOAD: begin
                     Read = 1'b1; MDRin = 1'b1;
                     if (!mem_ready) state_nxt = ST_T6;
                  end
                  CLS_STORE: begin rout_en = 1'b1; MDRin = 1'b1; end
                  default:   state_nxt = ST_T0;
               endcase
            end
            ST_T7: begin
               state_nxt = ST_T0;
               case (cls)
                  CLS_LOAD: begin MDRout = 1'b1; rin_en = 1'b1; done = 1'b1; end
                  CLS_STORE: begin
                     Write = 1'b1;
                     if (mem_ready) done = 1'b1;
                     else           state_nxt = ST_T7;
                  end
                  default: ;
               endcase
            end
            ST_HALT: ;
            default: state_nxt = ST_T0;
         endcase
         // Instruction boundary: the only place stop is looked at.
         if (done) state_nxt = (stop || halt_req) ? ST_HALT : ST_T0;
      end
   end

   assign instr_done = done;
   assign run        = clear || (state != ST_HALT);

   reg_select_decoder u_rout_dec (
      .field  (rout_field),
      .en     (rout_en),
      .onehot (Rout)
   );

   reg_select_decoder u_rin_dec (
      .field  (ra),
      .en     (rin_en),
      .onehot (Rin)
   );

   always_ff @(posedge clock) begin
      if (clear) state <= ST_T0;
      else       state <= state_nxt;
   end

`ifdef ILLEGAL_TRAP_EN
   always_ff @(posedge clock) begin
      if (clear)            illegal_q <= 1'b0;
      else if (illegal_set) illegal_q <= 1'b1;
   end
   assign illegal = illegal_q && !clear;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   typedef struct packed {
      logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, CSignOut;
      logic [15:0] Rout;
      logic [15:0] Rin;
      logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Write;
      logic [4:0] alu_op;
      logic run, instr_done, illegal;
   } sig_t;

   typedef struct {
      sig_t s;
      bit   mem;
      bit   last;
   } step_t;

   typedef struct {
      logic [4:0]  op;
      int          cycles;
      logic [15:0] t3_rout;
      logic [15:0] t3_rin;
   } vec_t;

   logic        clock, clear, mem_ready, stop;
   logic [31:0] ir;
   logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, CSignOut;
   logic [15:0] Rout, Rin;
   logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Write;
   logic [4:0] alu_op;
   logic run, instr_done, illegal;

   sig_t obs;
   assign obs = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, CSignOut,
                 Rout, Rin, MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn,
                 IncPC, Read, Write, alu_op, run, instr_done, illegal};

   int checks = 0;
   int failures = 0;
   step_t steps[$];
   vec_t  tbl[9];

   control_sequencer dut (
      .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .stop(stop),
      .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
      .HIout(HIout), .LOout(LOout), .Yout(Yout), .InPortout(InPortout),
      .CSignOut(CSignOut), .Rout(Rout), .Rin(Rin), .MARin(MARin), .PCin(PCin),
      .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
      .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .IncPC(IncPC), .Read(Read), .Write(Write),
      .alu_op(alu_op), .run(run), .instr_done(instr_done), .illegal(illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic sig_t base();
      sig_t b;
      b = '0;
      b.run = 1'b1;
      return b;
   endfunction

   function automatic sig_t t0_sig();
      sig_t s;
      s = base();
      s.PCout = 1'b1; s.MARin = 1'b1; s.IncPC = 1'b1;
      return s;
   endfunction

   task automatic chk(input string nm, input sig_t a, input sig_t e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, a, e);
      end
   endtask

   task automatic chk_int(input string nm, input int a, input int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, a, e);
      end
   endtask

   function automatic void push(input sig_t s, input bit mem, input bit last);
      step_t t;
      t.s = s; t.mem = mem; t.last = last;
      steps.push_back(t);
   endfunction

   // Reference: the list of micro-steps an instruction goes through, straight
   // from the instruction table. Memory steps repeat while mem_ready is low.
   function automatic void build(input logic [4:0] op, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic [3:0] rc);
      sig_t b, s;
      logic [15:0] a1, b1, c1;
      b  = base();
      a1 = 16'd1 << ra;
      b1 = 16'd1 << rb;
      c1 = 16'd1 << rc;
      steps.delete();
      push(t0_sig(), 0, 0);
      s = b; s.Read = 1; s.MDRin = 1; push(s, 1, 0);
      s = b; s.MDRout = 1; s.IRin = 1; push(s, 0, 0);
      if (op >= 5'd2 && op <= 5'd12) begin
         s = b; s.Rout = b1; s.Yin = 1; push(s, 0, 0);
         s = b; s.ZLowIn = 1;
         if (op <= 5'd9) begin
            s.Rout = c1; s.alu_op = op;
         end else begin
            s.CSignOut = 1;
            s.alu_op = (op == 5'd10) ? 5'd2 : (op == 5'd11) ? 5'd4 : 5'd5;
         end
         push(s, 0, 0);
         s = b; s.Zlowout = 1; s.Rin = a1; push(s, 0, 1);
      end else if (op == 5'd15 || op == 5'd16) begin
         s = b; s.Rout = b1; s.alu_op = op; s.ZLowIn = 1; push(s, 0, 0);
         s = b; s.Zlowout = 1; s.Rin = a1; push(s, 0, 1);
      end else if (op == 5'd13 || op == 5'd14) begin
         s = b; s.Rout = a1; s.Yin = 1; push(s, 0, 0);
         s = b; s.Rout = b1; s.alu_op = op; s.ZHighIn = 1; s.ZLowIn = 1; push(s, 0, 0);
         s = b; s.Zlowout = 1; s.LOin = 1; push(s, 0, 0);
         s = b; s.Zhighout = 1; s.HIin = 1; push(s, 0, 1);
      end else if (op <= 5'd1) begin
         s = b; s.Rout = b1; s.Yin = 1; push(s, 0, 0);
         s = b; s.CSignOut = 1; s.alu_op = 5'd2; s.ZLowIn = 1; push(s, 0, 0);
         s = b; s.Zlowout = 1; s.MARin = 1; push(s, 0, 0);
         if (op == 5'd0) begin
            s = b; s.Read = 1; s.MDRin = 1; push(s, 1, 0);
            s = b; s.MDRout = 1; s.Rin = a1; push(s, 0, 1);
         end else begin
            s = b; s.Rout = a1; s.MDRin = 1; push(s, 0, 0);
            s = b; s.Write = 1; push(s, 1, 1);
         end
      end else begin
         s = b;
         case (op)
            5'd17: begin s.Rout = a1; s.PCin = 1; end
            5'd18: begin s.InPortout = 1; s.Rin = a1; end
            5'd19: begin s.HIout = 1; s.Rin = a1; end
            5'd20: begin s.LOout = 1; s.Rin = a1; end
            default: ;
         endcase
         push(s, 0, 1);
      end
   endfunction

   // Returns with inputs changed 1 time unit after the edge that makes T0 current.
   task automatic do_clear();
      sig_t e;
      e = base();
      clear = 1'b1;
      @(negedge clock);
      chk("reset_state", obs, e);
      @(posedge clock); #1;
      clear = 1'b0;
   endtask

   task automatic run_instr(input logic [31:0] iv, input bit rand_mr, input string nm);
      sig_t e;
      bit adv;
      int waits;
      build(iv[31:27], iv[26:23], iv[22:19], iv[18:15]);
      ir = iv;
      for (int k = 0; k < steps.size(); k++) begin
         adv = 0;
         waits = 0;
         while (!adv) begin
            mem_ready = rand_mr ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (waits >= 6) mem_ready = 1'b1;
            @(negedge clock);
            e = steps[k].s;
            e.instr_done = steps[k].last && (!steps[k].mem || mem_ready);
            chk($sformatf("%s_op%0d_step%0d", nm, iv[31:27], k), obs, e);
            adv = !steps[k].mem || mem_ready;
            waits++;
            @(posedge clock); #1;
         end
      end
   endtask

   initial begin
      int n, nread;
      logic [15:0] r3o, r3i, rdone;
      logic [31:0] iv, r;
      bit wrote;
      sig_t e;

      clear = 1'b1; stop = 1'b0; mem_ready = 1'b0; ir = 32'h0;
      @(posedge clock); #1;

      tbl[0] = '{5'd2,  6, 16'h0004, 16'h0000};
      tbl[1] = '{5'd21, 4, 16'h0000, 16'h0000};
      tbl[2] = '{5'd13, 7, 16'h0002, 16'h0000};
      tbl[3] = '{5'd0,  8, 16'h0004, 16'h0000};
      tbl[4] = '{5'd1,  8, 16'h0004, 16'h0000};
      tbl[5] = '{5'd15, 5, 16'h0004, 16'h0000};
      tbl[6] = '{5'd17, 4, 16'h0002, 16'h0000};
      tbl[7] = '{5'd19, 4, 16'h0000, 16'h0002};
      tbl[8] = '{5'd10, 6, 16'h0004, 16'h0000};

      // Latency and T3 register selects, Ra=1 Rb=2 Rc=3, memory always ready
      for (int v = 0; v < 9; v++) begin
         do_clear();
         ir = {tbl[v].op, 4'd1, 4'd2, 4'd3, 15'd0};
         mem_ready = 1'b1;
         n = -1; r3o = 16'hxxxx; r3i = 16'hxxxx;
         for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (c == 3) begin r3o = Rout; r3i = Rin; end
            if (instr_done) begin n = c + 1; break; end
            @(posedge clock); #1;
         end
         @(posedge clock); #1;
         chk_int($sformatf("latency_op%0d", tbl[v].op), n, tbl[v].cycles);
         chk_int($sformatf("t3_rout_op%0d", tbl[v].op), int'(r3o), int'(tbl[v].t3_rout));
         chk_int($sformatf("t3_rin_op%0d", tbl[v].op), int'(r3i), int'(tbl[v].t3_rin));
      end

      // Full per-cycle check of the add example
      do_clear();
      run_instr(32'h1098_0000, 1'b0, "add_example");

      // ld with three wait cycles in T6
      do_clear();
      ir = {5'd0, 4'd1, 4'd2, 4'd3, 15'd0};
      n = -1; nread = 0; rdone = 16'h0;
      for (int c = 0; c < 30; c++) begin
         mem_ready = !(c >= 6 && c <= 8);
         @(negedge clock);
         if (c >= 3 && Read && MDRin) nread++;
         if (instr_done) begin n = c + 1; rdone = Rin; break; end
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
      chk_int("ld_wait_cycles", n, 11);
      chk_int("ld_read_hold", nread, 4);
      chk_int("ld_rin", int'(rdone), 16'h0002);

      // stop raised in T4 of add: completes, then parks in HALT
      do_clear();
      ir = 32'h1098_0000;
      mem_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 6; c++) begin
         stop = (c >= 4);
         @(negedge clock);
         if (c == 5) n = int'(instr_done);
         @(posedge clock); #1;
      end
      chk_int("stop_add_done", n, 1);
      for (int h = 0; h < 4; h++) begin
         r = $urandom();
         mem_ready = r[0]; stop = r[1];
         @(negedge clock);
         chk($sformatf("halt_idle%0d", h), obs, sig_t'('0));
         @(posedge clock); #1;
      end
      stop = 1'b0;
      do_clear();
      @(negedge clock);
      chk("t0_after_halt", obs, t0_sig());
      @(posedge clock); #1;

      // clear in T6 of st aborts before any Write
      do_clear();
      ir = {5'd1, 4'd4, 4'd5, 4'd6, 15'd0};
      mem_ready = 1'b1;
      wrote = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         wrote |= Write;
         @(posedge clock); #1;
      end
      mem_ready = 1'b0;
      clear = 1'b1;
      @(negedge clock);
      chk("clear_mid_st", obs, base());
      wrote |= Write;
      @(posedge clock); #1;
      clear = 1'b0;
      @(negedge clock);
      chk("t0_after_abort", obs, t0_sig());
      wrote |= Write;
      chk_int("st_no_write", int'(wrote), 0);
      @(posedge clock); #1;

      // Undefined opcode 11111
      do_clear();
`ifdef ILLEGAL_TRAP_EN
      ir = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};
      mem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock); @(posedge clock); #1;
      end
      @(negedge clock);
      chk("undef_t3", obs, base());
      @(posedge clock); #1;
      e = '0; e.illegal = 1'b1;
      for (int h = 0; h < 2; h++) begin
         @(negedge clock);
         chk($sformatf("undef_trap%0d", h), obs, e);
         @(posedge clock); #1;
      end
      do_clear();
      @(negedge clock);
      chk("t0_after_trap", obs, t0_sig());
      @(posedge clock); #1;
`else
      run_instr({5'b11111, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0, "undef_nop");
      @(negedge clock);
      chk("t0_after_undef", obs, t0_sig());
      @(posedge clock); #1;
`endif

      // Randomised instruction stream with random memory stalls
      do_clear();
      for (int t = 0; t < 60; t++) begin
         r  = $urandom();
         iv = {5'($urandom_range(0, 21)), r[26:0]};
         run_instr(iv, 1'b1, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
